// File: rtl/zmenu_nav_ctrl_pkg.sv
// rtl/zmenu_nav_ctrl_pkg.sv - shared button indices, navigator states and menu item indices
package zmenu_nav_ctrl_pkg;

   localparam int ZMENU_BTN_PREV   = 0;
   localparam int ZMENU_BTN_NEXT   = 1;
   localparam int ZMENU_BTN_OKAY   = 2;
   localparam int ZMENU_BTN_CANCEL = 3;

   localparam int ZCURSOR_INDEX_HOME      = 0;
   localparam int ZCURSOR_INDEX_SEL_FIRST = 1;
   localparam int ZCURSOR_INDEX_LAST      = 10;

   typedef enum logic [1:0] {
      ZNAV_IDLE = 2'd0,
      ZNAV_DLY  = 2'd1,
      ZNAV_RPT  = 2'd2
   } znav_state_e;

   function automatic int zmax3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/zbutton_debounce.sv
// rtl/zbutton_debounce.sv - one button: 2-flop sync, stable-level debounce, press pulse
module zbutton_debounce #(
   parameter int DEB_CYC = 20000,
   parameter int CNT_W   = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             rise_q, rise_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      // A press only counts once the button has been seen released while enabled.
      armed_d = armed_q | (~deb_q & ~sync2_q);
      if (sync2_q != deb_q) begin
         if (cnt_q == DEB_LAST) begin
            deb_d  = sync2_q;
            rise_d = sync2_q & armed_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (!en) begin
         deb_d   = 1'b0;
         cnt_d   = '0;
         rise_d  = 1'b0;
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         rise_q  <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = deb_q;
   assign rise  = rise_q;

endmodule

// File: rtl/zmenu_nav_ctrl.sv
// rtl/zmenu_nav_ctrl.sv - four-button menu navigator: wrap-around cursor, auto-repeat, select/cancel
module zmenu_nav_ctrl
   import zmenu_nav_ctrl_pkg::*;
#(
   parameter int CUR_W       = 4,
   parameter int CURSOR_MAX  = ZCURSOR_INDEX_LAST,
   parameter int SEL_BASE    = ZCURSOR_INDEX_SEL_FIRST,
   parameter int SEL_NUM     = 5,
   parameter int SEL_W       = 3,
   parameter int DEB_CYC     = 20000,
   parameter int RPT_DLY_CYC = 500000,
   parameter int RPT_CYC     = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       iButton,
   output logic [CUR_W-1:0] oCursor_Index,
   output logic [SEL_W-1:0] oSel_Value,
   output logic             oSel_Strobe,
   output logic             oCancel_Strobe
);

   localparam int               CNT_W     = $clog2(zmax3(DEB_CYC, RPT_DLY_CYC, RPT_CYC));
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);
   localparam logic [CUR_W-1:0] CUR_LAST  = CUR_W'(CURSOR_MAX);
   localparam logic [CUR_W-1:0] CUR_HOME  = CUR_W'(ZCURSOR_INDEX_HOME);
   localparam logic [CUR_W-1:0] SEL_FIRST = CUR_W'(SEL_BASE);
   localparam logic [CUR_W-1:0] SEL_END   = CUR_W'(SEL_BASE + SEL_NUM - 1);

   logic [3:0] btn_lvl;
   logic [3:0] btn_rise;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      zbutton_debounce #(
         .DEB_CYC (DEB_CYC),
         .CNT_W   (CNT_W)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .raw   (iButton[i]),
         .level (btn_lvl[i]),
         .rise  (btn_rise[i])
      );
   end

   logic unused_lvl;
   assign unused_lvl = &{1'b0, btn_lvl[ZMENU_BTN_CANCEL:ZMENU_BTN_OKAY]};

   znav_state_e      state_q, state_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CUR_W-1:0] cursor_q, cursor_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             sel_stb_q, sel_stb_d;
   logic             can_stb_q, can_stb_d;
   logic             step, step_up, held, both;

   // dir_q: 1 = Next latched, 0 = Prev latched
   assign held = dir_q ? btn_lvl[ZMENU_BTN_NEXT] : btn_lvl[ZMENU_BTN_PREV];
   assign both = btn_lvl[ZMENU_BTN_PREV] & btn_lvl[ZMENU_BTN_NEXT];

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      cursor_d  = cursor_q;
      sel_d     = sel_q;
      sel_stb_d = 1'b0;
      can_stb_d = 1'b0;
      step      = 1'b0;
      step_up   = dir_q;
      if (both) begin
         state_d = ZNAV_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ZNAV_IDLE: begin
               if (btn_rise[ZMENU_BTN_PREV] | btn_rise[ZMENU_BTN_NEXT]) begin
                  step    = 1'b1;
                  step_up = ~btn_rise[ZMENU_BTN_PREV];
                  dir_d   = ~btn_rise[ZMENU_BTN_PREV];
                  cnt_d   = '0;
                  state_d = ZNAV_DLY;
               end
            end
            ZNAV_DLY, ZNAV_RPT: begin
               if (!held) begin
                  state_d = ZNAV_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == ((state_q == ZNAV_DLY) ? DLY_LAST : RPT_LAST)) begin
                  step    = 1'b1;
                  cnt_d   = '0;
                  state_d = ZNAV_RPT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ZNAV_IDLE;
         endcase
      end
      if (step) begin
         if (step_up) cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_W'(1);
         else         cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - CUR_W'(1);
      end else if (btn_rise[ZMENU_BTN_OKAY]) begin
         if (cursor_q >= SEL_FIRST && cursor_q <= SEL_END) begin
            sel_d     = SEL_W'(cursor_q - SEL_FIRST);
            sel_stb_d = 1'b1;
         end
      end else if (btn_rise[ZMENU_BTN_CANCEL]) begin
         cursor_d  = SEL_FIRST + CUR_W'(sel_q);
         can_stb_d = 1'b1;
      end
      if (!en) begin
         state_d   = ZNAV_IDLE;
         dir_d     = 1'b0;
         cnt_d     = '0;
         cursor_d  = CUR_HOME;
         sel_d     = '0;
         sel_stb_d = 1'b0;
         can_stb_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ZNAV_IDLE;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         cursor_q  <= CUR_HOME;
         sel_q     <= '0;
         sel_stb_q <= 1'b0;
         can_stb_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         cursor_q  <= cursor_d;
         sel_q     <= sel_d;
         sel_stb_q <= sel_stb_d;
         can_stb_q <= can_stb_d;
      end
   end

   assign oCursor_Index  = cursor_q;
   assign oSel_Value     = sel_q;
   assign oSel_Strobe    = sel_stb_q;
   assign oCancel_Strobe = can_stb_q;

endmodule

// File: tb/tb_zmenu_nav_ctrl.sv
// tb/tb_zmenu_nav_ctrl.sv - directed bench for zmenu_nav_ctrl with short debounce/repeat times
module tb_zmenu_nav_ctrl;
   import zmenu_nav_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] btn;
   logic [3:0] cur;
   logic [2:0] sel;
   logic       sel_stb, can_stb;

   int n_tests = 0;
   int n_fail  = 0;
   int sel_cnt = 0;
   int can_cnt = 0;
   int both_cnt = 0;

   always #5 clk = ~clk;

   zmenu_nav_ctrl #(
      .DEB_CYC     (4),
      .RPT_DLY_CYC (20),
      .RPT_CYC     (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .iButton        (btn),
      .oCursor_Index  (cur),
      .oSel_Value     (sel),
      .oSel_Strobe    (sel_stb),
      .oCancel_Strobe (can_stb)
   );

   always @(negedge clk) begin
      if (sel_stb === 1'b1) sel_cnt++;
      if (can_stb === 1'b1) can_cnt++;
      if (sel_stb === 1'b1 && can_stb === 1'b1) both_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tap(input int b, input int hold);
      btn[b] = 1'b1;
      cyc(hold);
      btn[b] = 1'b0;
      cyc(20);
   endtask

   int edges[$];
   int exp_edges[6] = '{7, 27, 35, 43, 51, 59};
   logic [3:0] prev_cur;
   int s0;

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      btn   = 4'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      check_eq("rst_cursor", cur, 0);
      check_eq("rst_sel", sel, 0);
      check_eq("rst_sel_stb", sel_stb, 0);
      check_eq("rst_can_stb", can_stb, 0);

      // 1: Next taps count up and wrap after item 10
      for (int i = 1; i <= 11; i++) begin
         tap(ZMENU_BTN_NEXT, 10);
         check_eq($sformatf("next_tap%0d", i), cur, i % 11);
      end
      tap(ZMENU_BTN_PREV, 10);
      check_eq("prev_wrap", cur, 10);
      tap(ZMENU_BTN_NEXT, 10);
      check_eq("next_wrap", cur, 0);

      // 2: glitch rejection, then a short clean press steps once
      tap(ZMENU_BTN_NEXT, 3);
      check_eq("glitch", cur, 0);
      tap(ZMENU_BTN_NEXT, 10);
      check_eq("short_press", cur, 1);
      tap(ZMENU_BTN_PREV, 10);
      check_eq("back_to_0", cur, 0);

      // 3: hold Next 60 cycles, log the edges at which the cursor moves
      btn[ZMENU_BTN_NEXT] = 1'b1;
      for (int c = 0; c < 90; c++) begin
         prev_cur = cur;
         cyc(1);
         if (cur !== prev_cur) edges.push_back(c + 1);
         if (c == 59) btn[ZMENU_BTN_NEXT] = 1'b0;
      end
      check_eq("hold_steps", edges.size(), 6);
      for (int k = 0; k < 6; k++)
         check_eq($sformatf("hold_edge%0d", k), (k < edges.size()) ? edges[k] : -1, exp_edges[k]);
      check_eq("hold_cursor", cur, 6);

      // 4: select on a selectable item, then ignored select on item 0
      for (int i = 0; i < 3; i++) tap(ZMENU_BTN_PREV, 10);
      check_eq("t4_cursor", cur, 3);
      s0 = sel_cnt;
      tap(ZMENU_BTN_OKAY, 10);
      check_eq("okay_value", sel, 2);
      check_eq("okay_strobes", sel_cnt - s0, 1);
      for (int i = 0; i < 3; i++) tap(ZMENU_BTN_PREV, 10);
      check_eq("t4_cursor0", cur, 0);
      s0 = sel_cnt;
      tap(ZMENU_BTN_OKAY, 10);
      check_eq("okay_nonsel_strobes", sel_cnt - s0, 0);
      check_eq("okay_nonsel_value", sel, 2);

      // 5: cancel snaps back to committed item; Prev+Next together freezes
      tap(ZMENU_BTN_PREV, 10);
      tap(ZMENU_BTN_PREV, 10);
      check_eq("t5_cursor9", cur, 9);
      s0 = can_cnt;
      tap(ZMENU_BTN_CANCEL, 10);
      check_eq("cancel_cursor", cur, 3);
      check_eq("cancel_strobes", can_cnt - s0, 1);
      check_eq("cancel_value", sel, 2);
      btn[ZMENU_BTN_PREV] = 1'b1;
      btn[ZMENU_BTN_NEXT] = 1'b1;
      cyc(40);
      check_eq("both_held", cur, 3);
      btn[ZMENU_BTN_PREV] = 1'b0;
      btn[ZMENU_BTN_NEXT] = 1'b0;
      cyc(20);
      check_eq("both_released", cur, 3);

      // 6: drop en mid-repeat, re-enable with Prev still held
      btn[ZMENU_BTN_PREV] = 1'b1;
      cyc(31);
      check_eq("t6_before_en", cur, 1);
      en = 1'b0;
      cyc(1);
      check_eq("en_cursor", cur, 0);
      check_eq("en_sel", sel, 0);
      check_eq("en_sel_stb", sel_stb, 0);
      check_eq("en_can_stb", can_stb, 0);
      cyc(5);
      en = 1'b1;
      cyc(40);
      check_eq("reen_held", cur, 0);
      btn[ZMENU_BTN_PREV] = 1'b0;
      cyc(20);
      check_eq("reen_released", cur, 0);
      tap(ZMENU_BTN_PREV, 10);
      check_eq("reen_repress", cur, 10);

      check_eq("strobe_overlap", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
